// File: rtl/afa_pkg.sv
// Shared definitions for the signal_mux / signal_demux pair.
// Holds the default sample width and the mux/demux FSM state encodings.
package afa_pkg;

    localparam int NB_SAMPLE_DEF = 8;

    typedef enum logic {
        IDLE   = 1'b0,
        SEND_D = 1'b1
    } mux_state_e;

endpackage

// File: rtl/signal_mux_if.sv
// Sample/slot bus between a sample source and signal_mux.
// master: drives i_enable, i_valid, i_xn, i_dn; slave: drives o_* outputs.
interface signal_mux_if #(
    parameter int NB_SAMPLE = afa_pkg::NB_SAMPLE_DEF
);

    logic                        i_enable;
    logic                        i_valid;
    logic signed [NB_SAMPLE-1:0] i_xn;
    logic signed [NB_SAMPLE-1:0] i_dn;
    logic signed [NB_SAMPLE-1:0] o_signals;
    logic                        o_sel;
    logic                        o_strobe;
    logic                        o_busy;
    logic                        o_ovf;

    modport master (
        output i_enable, i_valid, i_xn, i_dn,
        input  o_signals, o_sel, o_strobe, o_busy, o_ovf
    );

    modport slave (
        input  i_enable, i_valid, i_xn, i_dn,
        output o_signals, o_sel, o_strobe, o_busy, o_ovf
    );

endinterface

// File: rtl/tick_detect.sv
// Rising-edge detector for a slow level clock; one tick per high phase.
// Ports: clk, rst (async high), i_level (slow level), o_tick (comb pulse).
module tick_detect (
    input  logic clk,
    input  logic rst,
    input  logic i_level,
    output logic o_tick
);

    logic prev_q;
    // armed_q blocks a tick from a level that was already high at reset
    // release; the level must be seen low once before it can rise.
    logic armed_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_q  <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            prev_q <= i_level;
            if (!i_level) begin
                armed_q <= 1'b1;
            end
        end
    end

    assign o_tick = i_level & ~prev_q & armed_q;

endmodule

// File: rtl/signal_mux.sv
// Time-multiplexes xn/dn sample pairs onto one bus, one sample per slot tick.
// Ports: clk, rst (async high), bus (signal_mux_if.slave: slot/sample in, mux out).
module signal_mux
    import afa_pkg::*;
#(
    parameter int NB_SAMPLE = NB_SAMPLE_DEF
) (
    input  logic         clk,
    input  logic         rst,
    signal_mux_if.slave  bus
);

    typedef logic signed [NB_SAMPLE-1:0] sample_t;

    logic       tick;
    mux_state_e state_q, state_d;
    sample_t    pend_xn_q, pend_xn_d;
    sample_t    pend_dn_q, pend_dn_d;
    sample_t    fly_dn_q, fly_dn_d;
    logic       pend_q, pend_d;
    sample_t    sig_q, sig_d;
    logic       sel_q, sel_d;
    logic       strobe_q, strobe_d;
    logic       ovf_q, ovf_d;
    logic       consume;

    tick_detect u_tick (
        .clk     (clk),
        .rst     (rst),
        .i_level (bus.i_enable),
        .o_tick  (tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            pend_xn_q <= '0;
            pend_dn_q <= '0;
            fly_dn_q  <= '0;
            pend_q    <= 1'b0;
            sig_q     <= '0;
            sel_q     <= 1'b0;
            strobe_q  <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            pend_xn_q <= pend_xn_d;
            pend_dn_q <= pend_dn_d;
            fly_dn_q  <= fly_dn_d;
            pend_q    <= pend_d;
            sig_q     <= sig_d;
            sel_q     <= sel_d;
            strobe_q  <= strobe_d;
            ovf_q     <= ovf_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pend_xn_d = pend_xn_q;
        pend_dn_d = pend_dn_q;
        fly_dn_d  = fly_dn_q;
        pend_d    = pend_q;
        sig_d     = sig_q;
        sel_d     = sel_q;
        strobe_d  = 1'b0;
        ovf_d     = ovf_q;
        consume   = 1'b0;

        case (state_q)
            IDLE: begin
                if (tick && pend_q) begin
                    consume  = 1'b1;
                    sig_d    = pend_xn_q;
                    sel_d    = 1'b0;
                    strobe_d = 1'b1;
                    fly_dn_d = pend_dn_q;
                    pend_d   = 1'b0;
                    state_d  = SEND_D;
                end
            end
            SEND_D: begin
                if (tick) begin
                    sig_d    = fly_dn_q;
                    sel_d    = 1'b1;
                    strobe_d = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // A new pair always lands in the pending slot; it only counts as an
        // overrun when the old pair was not taken by a tick this cycle.
        if (bus.i_valid) begin
            pend_xn_d = bus.i_xn;
            pend_dn_d = bus.i_dn;
            pend_d    = 1'b1;
            if (pend_q && !consume) begin
                ovf_d = 1'b1;
            end
        end
    end

    assign bus.o_signals = sig_q;
    assign bus.o_sel     = sel_q;
    assign bus.o_strobe  = strobe_q;
    assign bus.o_busy    = (state_q == SEND_D) | pend_q;
    assign bus.o_ovf     = ovf_q;

endmodule

// File: tb/tb_signal_mux.sv
// Self-checking bench for signal_mux: scoreboard of expected bus samples.
// Drives on negedge, samples on negedge after the active posedge.
module tb_signal_mux;

    localparam int NB = 8;

    typedef struct packed {
        logic [NB-1:0] data;
        logic          sel;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    exp_t got[$];

    always #5 clk = ~clk;

    signal_mux_if #(.NB_SAMPLE(NB)) bus ();

    signal_mux #(.NB_SAMPLE(NB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    task automatic send_pair(input logic [NB-1:0] xn, input logic [NB-1:0] dn);
        bus.i_valid = 1'b1;
        bus.i_xn    = xn;
        bus.i_dn    = dn;
        @(negedge clk);
        bus.i_valid = 1'b0;
    endtask

    // One i_enable high phase of 'hold' clocks, optionally with a same-cycle
    // i_valid; every observed strobe is recorded into got[].
    task automatic tick(input int hold, input logic vld,
                        input logic [NB-1:0] xn, input logic [NB-1:0] dn,
                        output int n);
        n = 0;
        bus.i_enable = 1'b1;
        if (vld) begin
            bus.i_valid = 1'b1;
            bus.i_xn    = xn;
            bus.i_dn    = dn;
        end
        for (int i = 0; i < hold + 1; i++) begin
            if (i == hold) bus.i_enable = 1'b0;
            @(negedge clk);
            bus.i_valid = 1'b0;
            if (bus.o_strobe === 1'b1) begin
                n++;
                got.push_back({bus.o_signals, bus.o_sel});
            end
        end
    endtask

    task automatic test_reset();
        int n;
        bus.i_enable = 1'b1;
        bus.i_valid  = 1'b0;
        bus.i_xn     = '0;
        bus.i_dn     = '0;
        rst          = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.o_signals, bus.o_sel, bus.o_strobe, bus.o_busy, bus.o_ovf} !== '0)
            begin
            errors++;
            $display("FAIL reset_outputs: got sig=%h sel=%b stb=%b busy=%b ovf=%b expected all 0",
                     bus.o_signals, bus.o_sel, bus.o_strobe, bus.o_busy, bus.o_ovf);
        end
        rst = 1'b0;
        n = 0;
        repeat (10) begin
            @(negedge clk);
            if (bus.o_strobe === 1'b1) n++;
        end
        checks++;
        if (n !== 0) begin
            errors++;
            $display("FAIL reset_enable_high: got %0d strobes expected 0", n);
        end
        bus.i_enable = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single_pair();
        int n;
        exp_t g, e;
        sb.delete();
        got.delete();
        send_pair(8'h35, 8'hC8);
        sb.push_back({8'h35, 1'b0});
        sb.push_back({8'hC8, 1'b1});
        checks++;
        if (bus.o_busy !== 1'b1) begin
            errors++;
            $display("FAIL single_busy_pend: got %b expected 1", bus.o_busy);
        end
        tick(1, 1'b0, '0, '0, n);
        checks++;
        if (n !== 1 || bus.o_busy !== 1'b1) begin
            errors++;
            $display("FAIL single_tick1: got n=%0d busy=%b expected n=1 busy=1", n, bus.o_busy);
        end
        tick(1, 1'b0, '0, '0, n);
        checks++;
        if (n !== 1 || bus.o_busy !== 1'b0) begin
            errors++;
            $display("FAIL single_tick2: got n=%0d busy=%b expected n=1 busy=0", n, bus.o_busy);
        end
        while (sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            if (got.size() == 0) begin
                errors++;
                $display("FAIL single_data: got no strobe expected %h/%b", e.data, e.sel);
            end else begin
                g = got.pop_front();
                if (g !== e) begin
                    errors++;
                    $display("FAIL single_data: got %h/%b expected %h/%b",
                             g.data, g.sel, e.data, e.sel);
                end
            end
        end
    endtask

    task automatic test_idle_tick();
        int n;
        got.delete();
        tick(3, 1'b0, '0, '0, n);
        checks++;
        if (n !== 0) begin
            errors++;
            $display("FAIL idle_strobe: got %0d strobes expected 0", n);
        end
        checks++;
        if (bus.o_signals !== 8'hC8 || bus.o_sel !== 1'b1) begin
            errors++;
            $display("FAIL idle_hold: got %h/%b expected c8/1", bus.o_signals, bus.o_sel);
        end
    endtask

    task automatic test_long_enable();
        int n1, n2;
        exp_t g, e;
        sb.delete();
        got.delete();
        send_pair(8'h5A, 8'hA5);
        sb.push_back({8'h5A, 1'b0});
        sb.push_back({8'hA5, 1'b1});
        tick(10, 1'b0, '0, '0, n1);
        tick(1, 1'b0, '0, '0, n2);
        checks++;
        if (n1 !== 1 || n2 !== 1) begin
            errors++;
            $display("FAIL long_enable_count: got %0d,%0d expected 1,1", n1, n2);
        end
        while (sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            if (got.size() == 0) begin
                errors++;
                $display("FAIL long_data: got no strobe expected %h/%b", e.data, e.sel);
            end else begin
                g = got.pop_front();
                if (g !== e) begin
                    errors++;
                    $display("FAIL long_data: got %h/%b expected %h/%b",
                             g.data, g.sel, e.data, e.sel);
                end
            end
        end
    endtask

    task automatic test_same_cycle();
        int n, total;
        exp_t g, e;
        sb.delete();
        got.delete();
        total = 0;
        send_pair(8'h01, 8'h02);
        tick(1, 1'b1, 8'h03, 8'h04, n);
        total += n;
        repeat (3) begin
            tick(1, 1'b0, '0, '0, n);
            total += n;
        end
        sb.push_back({8'h01, 1'b0});
        sb.push_back({8'h02, 1'b1});
        sb.push_back({8'h03, 1'b0});
        sb.push_back({8'h04, 1'b1});
        tick(1, 1'b1, 8'h55, 8'h66, n);
        checks++;
        if (n !== 0 || bus.o_busy !== 1'b1) begin
            errors++;
            $display("FAIL capture_only: got n=%0d busy=%b expected n=0 busy=1", n, bus.o_busy);
        end
        repeat (2) begin
            tick(1, 1'b0, '0, '0, n);
            total += n;
        end
        sb.push_back({8'h55, 1'b0});
        sb.push_back({8'h66, 1'b1});
        send_pair(8'h71, 8'h72);
        tick(1, 1'b0, '0, '0, n);
        total += n;
        send_pair(8'h73, 8'h74);
        repeat (3) begin
            tick(1, 1'b0, '0, '0, n);
            total += n;
        end
        sb.push_back({8'h71, 1'b0});
        sb.push_back({8'h72, 1'b1});
        sb.push_back({8'h73, 1'b0});
        sb.push_back({8'h74, 1'b1});
        checks++;
        if (total !== 10 || bus.o_ovf !== 1'b0 || bus.o_busy !== 1'b0) begin
            errors++;
            $display("FAIL same_cycle_summary: got n=%0d ovf=%b busy=%b expected 10/0/0",
                     total, bus.o_ovf, bus.o_busy);
        end
        while (sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            if (got.size() == 0) begin
                errors++;
                $display("FAIL same_cycle_data: got no strobe expected %h/%b", e.data, e.sel);
            end else begin
                g = got.pop_front();
                if (g !== e) begin
                    errors++;
                    $display("FAIL same_cycle_data: got %h/%b expected %h/%b",
                             g.data, g.sel, e.data, e.sel);
                end
            end
        end
    endtask

    task automatic test_overrun();
        int n;
        exp_t g, e;
        sb.delete();
        got.delete();
        send_pair(8'h11, 8'h22);
        send_pair(8'h33, 8'h44);
        checks++;
        if (bus.o_ovf !== 1'b1) begin
            errors++;
            $display("FAIL overrun_flag: got %b expected 1", bus.o_ovf);
        end
        sb.push_back({8'h33, 1'b0});
        sb.push_back({8'h44, 1'b1});
        repeat (3) tick(1, 1'b0, '0, '0, n);
        checks++;
        if (bus.o_ovf !== 1'b1 || bus.o_busy !== 1'b0) begin
            errors++;
            $display("FAIL overrun_sticky: got ovf=%b busy=%b expected 1/0", bus.o_ovf, bus.o_busy);
        end
        checks++;
        if (got.size() !== sb.size()) begin
            errors++;
            $display("FAIL overrun_count: got %0d strobes expected %0d", got.size(), sb.size());
        end
        while (sb.size() > 0 && got.size() > 0) begin
            e = sb.pop_front();
            g = got.pop_front();
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL overrun_data: got %h/%b expected %h/%b",
                         g.data, g.sel, e.data, e.sel);
            end
        end
    endtask

    task automatic test_reset_mid_pair();
        int n;
        exp_t g, e;
        sb.delete();
        got.delete();
        send_pair(8'h7F, 8'h10);
        tick(1, 1'b0, '0, '0, n);
        sb.push_back({8'h7F, 1'b0});
        rst = 1'b1;
        #1;
        checks++;
        if ({bus.o_signals, bus.o_sel, bus.o_strobe, bus.o_busy, bus.o_ovf} !== '0)
            begin
            errors++;
            $display("FAIL mid_reset_outputs: got sig=%h sel=%b stb=%b busy=%b ovf=%b expected all 0",
                     bus.o_signals, bus.o_sel, bus.o_strobe, bus.o_busy, bus.o_ovf);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        tick(1, 1'b0, '0, '0, n);
        checks++;
        if (n !== 0 || bus.o_signals !== 8'h00) begin
            errors++;
            $display("FAIL post_reset_tick: got n=%0d sig=%h expected 0/00", n, bus.o_signals);
        end
        send_pair(8'h2B, 8'h3C);
        sb.push_back({8'h2B, 1'b0});
        sb.push_back({8'h3C, 1'b1});
        repeat (2) tick(1, 1'b0, '0, '0, n);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            if (got.size() == 0) begin
                errors++;
                $display("FAIL mid_reset_data: got no strobe expected %h/%b", e.data, e.sel);
            end else begin
                g = got.pop_front();
                if (g !== e) begin
                    errors++;
                    $display("FAIL mid_reset_data: got %h/%b expected %h/%b",
                             g.data, g.sel, e.data, e.sel);
                end
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst          = 1'b1;
        bus.i_enable = 1'b0;
        bus.i_valid  = 1'b0;
        bus.i_xn     = '0;
        bus.i_dn     = '0;
        @(negedge clk);
        test_reset();
        test_single_pair();
        test_idle_tick();
        test_long_enable();
        test_same_cycle();
        test_overrun();
        test_reset_mid_pair();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
